speed_ramp_pwm: RTL

//  Downstream consumer of the throttle stage. Takes slow_clk (ramp tick source) and freq_num
//  (speed level 0..5) and drives a PWM motor output whose duty ramps toward the selected level.

---
 rtl/speed_ramp_pwm.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/speed_ramp_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : speed_ramp_pwm
//  Description : Speed-level to PWM motor drive. The duty cycle ramps toward
//                level*LEVEL_DUTY by RAMP_STEP on every slow_clk rising edge.
//                A direction change is committed only once the duty has
//                ramped down to zero. Emergency stop forces duty to zero at
//                once. Free-running PWM counter with a registered output.
//  Revision    : 1.0  initial release
// ============================================================================
module speed_ramp_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int LEVEL_DUTY = 51,
    parameter int RAMP_STEP  = 4,
    parameter int MAX_LEVEL  = 5
) (
    input  logic                CLK_50,
    input  logic                reset,
    input  logic                slow_clk,
    input  logic [2:0]          freq_num,
    input  logic                dir_req,
    input  logic                estop,
    output logic                pwm_out,
    output logic                dir_out,
    output logic [PWM_BITS-1:0] duty,
    output logic                at_speed,
    output logic [1:0]          state
);

    // Largest duty value the PWM counter can express.
    localparam int unsigned c_DUTY_MAX = (2 ** PWM_BITS) - 1;

    typedef enum logic [1:0] {
        ST_STOP    = 2'b00,
        ST_RAMP    = 2'b01,
        ST_CRUISE  = 2'b10,
        ST_REVERSE = 2'b11
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_dir;
    logic                r_slow_q;
    logic [PWM_BITS-1:0] r_cnt;
    logic                r_pwm;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic                w_tick;
    logic                w_dir_mismatch;
    logic [31:0]         w_lvl;
    logic [31:0]         w_tgt_wide;
    logic [PWM_BITS-1:0] w_tgt;
    logic [PWM_BITS-1:0] w_goal;
    logic [PWM_BITS-1:0] w_diff_up;
    logic [PWM_BITS-1:0] w_diff_dn;
    logic [PWM_BITS-1:0] w_step_duty;
    state_t              w_state_nxt;
    logic [PWM_BITS-1:0] w_duty_nxt;
    logic                w_dir_nxt;

    // Delayed copy of slow_clk so each rising edge yields a single-cycle tick.
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            r_slow_q <= 1'b0;
        end else begin
            r_slow_q <= slow_clk;
        end
    end

    assign w_tick         = slow_clk & ~r_slow_q;
    assign w_dir_mismatch = (dir_req != r_dir);

    // Target duty: clamp the level, scale it, saturate to the counter range.
    always_comb begin
        w_lvl = {29'd0, freq_num};
        if (w_lvl > 32'(MAX_LEVEL)) begin
            w_lvl = 32'(MAX_LEVEL);
        end
        w_tgt_wide = w_lvl * 32'(LEVEL_DUTY);
        if (w_tgt_wide > 32'(c_DUTY_MAX)) begin
            w_tgt = '1;
        end else begin
            w_tgt = w_tgt_wide[PWM_BITS-1:0];
        end
    end

    // While reversing the duty must head to zero whatever the level says.
    assign w_goal    = (r_state == ST_REVERSE) ? '0 : w_tgt;
    assign w_diff_up = w_goal - r_duty;
    assign w_diff_dn = r_duty - w_goal;

    // One ramp step toward the goal, landing exactly on it rather than past it.
    always_comb begin
        w_step_duty = r_duty;
        if (r_duty < w_goal) begin
            if (w_diff_up > PWM_BITS'(RAMP_STEP)) begin
                w_step_duty = r_duty + PWM_BITS'(RAMP_STEP);
            end else begin
                w_step_duty = w_goal;
            end
        end else if (r_duty > w_goal) begin
            if (w_diff_dn > PWM_BITS'(RAMP_STEP)) begin
                w_step_duty = r_duty - PWM_BITS'(RAMP_STEP);
            end else begin
                w_step_duty = w_goal;
            end
        end
    end

    // Next-state decode: estop first, then direction handling, then ramping.
    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_dir_nxt   = r_dir;
        if (estop) begin
            w_state_nxt = ST_STOP;
            w_duty_nxt  = '0;
        end else begin
            case (r_state)
                ST_STOP: begin
                    // Duty is zero here, so a new direction is safe to apply.
                    if (w_dir_mismatch) begin
                        w_dir_nxt = dir_req;
                    end else if (w_tgt != '0) begin
                        w_state_nxt = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    if (w_dir_mismatch) begin
                        w_state_nxt = ST_REVERSE;
                    end else if (r_duty == w_tgt) begin
                        w_state_nxt = (w_tgt != '0) ? ST_CRUISE : ST_STOP;
                    end else if (w_tick) begin
                        w_duty_nxt = w_step_duty;
                    end
                end
                ST_CRUISE: begin
                    if (w_dir_mismatch) begin
                        w_state_nxt = ST_REVERSE;
                    end else if (w_tgt != r_duty) begin
                        w_state_nxt = ST_RAMP;
                    end
                end
                ST_REVERSE: begin
                    // Request withdrawn before reaching zero: resume normal ramp.
                    if (!w_dir_mismatch) begin
                        w_state_nxt = ST_RAMP;
                    end else if (r_duty == '0) begin
                        w_dir_nxt   = dir_req;
                        w_state_nxt = ST_STOP;
                    end else if (w_tick) begin
                        w_duty_nxt = w_step_duty;
                    end
                end
                default: begin
                    w_state_nxt = ST_STOP;
                    w_duty_nxt  = '0;
                end
            endcase
        end
    end

    // Control registers: state, applied duty and applied direction.
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
            r_duty  <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Free-running PWM counter and registered compare output.
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_pwm <= 1'b0;
        end else begin
            r_cnt <= r_cnt + PWM_BITS'(1);
            r_pwm <= (r_cnt < r_duty);
        end
    end

    assign pwm_out  = r_pwm;
    assign dir_out  = r_dir;
    assign duty     = r_duty;
    assign state    = r_state;
    assign at_speed = (r_state == ST_CRUISE);

endmodule
`default_nettype wire
